// File: rtl/nms_corner_collector_pkg.sv
// Shared definitions for the NMS corner collector: score-record layout, stream widths,
// FSM states and the neighbour-score helper used by the suppression compare.
package nms_corner_collector_pkg;

    localparam int COORD_W = 10;
    localparam int SCORE_W = 13;
    localparam int REC_W   = 34;
    localparam int DATA_W  = 2 * COORD_W + SCORE_W;
    localparam int CNT_W   = 10;

    localparam int X_MSB         = 33;
    localparam int X_LSB         = 24;
    localparam int Y_MSB         = 23;
    localparam int Y_LSB         = 14;
    localparam int IS_CORNER_BIT = 13;
    localparam int SCORE_MSB     = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_EOF    = 2'd2
    } state_t;

    // A neighbour that is not itself a corner competes with score 0.
    function automatic logic [SCORE_W-1:0] eff_score(input logic [REC_W-1:0] rec);
        return rec[IS_CORNER_BIT] ? rec[SCORE_MSB:0] : '0;
    endfunction

endpackage

// File: rtl/nms_corner_collector_if.sv
// Corner output stream: valid/ready handshake carrying {x,y,score} words and the EOF marker.
interface nms_corner_collector_if;

    logic                                      m_valid;
    logic                                      m_ready;
    logic [nms_corner_collector_pkg::DATA_W-1:0] m_data;
    logic                                      m_last;

    modport master (output m_valid, m_data, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_last, output m_ready);

endinterface

// File: rtl/nms_corner_collector_fifo.sv
// Single-clock FIFO holding corner words plus their last flag; read data is the head entry.
module corner_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int W     = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nms_corner_collector.sv
// NMS corner collector: suppresses non-maximal window centres, queues survivors and
// closes each frame with a count token on the output stream.
module nms_corner_collector
    import nms_corner_collector_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_CORNERS = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  win_vld,
    input  logic [REC_W-1:0]      w00,
    input  logic [REC_W-1:0]      w01,
    input  logic [REC_W-1:0]      w02,
    input  logic [REC_W-1:0]      w10,
    input  logic [REC_W-1:0]      w11,
    input  logic [REC_W-1:0]      w12,
    input  logic [REC_W-1:0]      w20,
    input  logic [REC_W-1:0]      w21,
    input  logic [REC_W-1:0]      w22,
    input  logic                  frame_start,
    input  logic                  frame_end,
    nms_corner_collector_if.master stream,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [SCORE_W-1:0] c_score;
    logic               s1_vld, s1_fe, s1_is_corner;
    logic [7:0]         s1_cmp;
    logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
    logic [SCORE_W-1:0] s1_score, s2_score;
    logic               s2_survive, s2_fe;

    state_t             state, next_state;
    logic               start_clear, push_corner, drop_corner, push_eof, room;
    logic [CNT_W-1:0]   frame_count;

    logic               fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [REC_W-1:0]   fifo_wr_data, fifo_rd_data;
    logic [FCW-1:0]     fifo_count;

    logic               unused_bits;

    assign c_score = w11[SCORE_MSB:0];
    assign unused_bits = ^{w00[X_MSB:Y_LSB], w01[X_MSB:Y_LSB], w02[X_MSB:Y_LSB],
                           w10[X_MSB:Y_LSB], w12[X_MSB:Y_LSB], w20[X_MSB:Y_LSB],
                           w21[X_MSB:Y_LSB], w22[X_MSB:Y_LSB]};

    // Earlier raster neighbours need a strict win, later ones only a tie, so plateaus keep one peak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld       <= 1'b0;
            s1_fe        <= 1'b0;
            s1_is_corner <= 1'b0;
            s1_cmp       <= '0;
            s1_x         <= '0;
            s1_y         <= '0;
            s1_score     <= '0;
        end else if (ce) begin
            s1_vld       <= win_vld;
            s1_fe        <= frame_end;
            s1_is_corner <= w11[IS_CORNER_BIT];
            s1_cmp       <= {c_score >  eff_score(w00), c_score >  eff_score(w01),
                             c_score >  eff_score(w02), c_score >  eff_score(w10),
                             c_score >= eff_score(w12), c_score >= eff_score(w20),
                             c_score >= eff_score(w21), c_score >= eff_score(w22)};
            s1_x         <= w11[X_MSB:X_LSB];
            s1_y         <= w11[Y_MSB:Y_LSB];
            s1_score     <= c_score;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_survive <= 1'b0;
            s2_fe      <= 1'b0;
            s2_x       <= '0;
            s2_y       <= '0;
            s2_score   <= '0;
        end else if (ce) begin
            s2_survive <= s1_vld & s1_is_corner & (&s1_cmp);
            s2_fe      <= s1_fe;
            s2_x       <= s1_x;
            s2_y       <= s1_y;
            s2_score   <= s1_score;
        end
    end

    // One FIFO slot is always held back for the EOF token.
    assign room = (int'(fifo_count) < FIFO_DEPTH - 1) && (int'(frame_count) < MAX_CORNERS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (ce && frame_start) next_state = ST_ACTIVE;
            ST_ACTIVE: if (ce && s2_fe)       next_state = ST_EOF;
            ST_EOF:    if (ce && !fifo_full)  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        start_clear = 1'b0;
        push_corner = 1'b0;
        drop_corner = 1'b0;
        push_eof    = 1'b0;
        case (state)
            ST_IDLE:   start_clear = ce & frame_start;
            ST_ACTIVE: begin
                push_corner = ce & s2_survive & room;
                drop_corner = ce & s2_survive & ~room;
            end
            ST_EOF:    push_eof = ce & ~fifo_full;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
        end else if (start_clear) begin
            frame_count <= '0;
            drop_cnt    <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push_corner) begin
                frame_count <= frame_count + 1'b1;
            end
            if (drop_corner) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    assign fifo_wr_en   = push_corner | push_eof;
    assign fifo_wr_data = push_eof ? {1'b1, {(2*COORD_W){1'b0}}, SCORE_W'(frame_count)}
                                   : {1'b0, s2_x, s2_y, s2_score};
    assign fifo_rd_en   = ~fifo_empty & stream.m_ready;

    corner_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign stream.m_valid = ~fifo_empty;
    assign stream.m_data  = fifo_empty ? '0 : fifo_rd_data[DATA_W-1:0];
    assign stream.m_last  = ~fifo_empty & fifo_rd_data[DATA_W];

endmodule

// File: tb/tb_nms_corner_collector.sv
// Randomised scoreboard bench for nms_corner_collector: a window-level NMS model predicts
// the corner stream and EOF token, and a monitor checks every accepted output word.
module tb_nms_corner_collector;
    import nms_corner_collector_pkg::*;

    localparam int FIFO_DEPTH  = 64;
    localparam int MAX_CORNERS = 1000;

    typedef logic [8:0][REC_W-1:0] win_t;
    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [15:0]       drops;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;
    logic win_vld = 1'b0;
    logic frame_start = 1'b0;
    logic frame_end = 1'b0;
    logic [REC_W-1:0] w00 = '0, w01 = '0, w02 = '0, w10 = '0, w11 = '0;
    logic [REC_W-1:0] w12 = '0, w20 = '0, w21 = '0, w22 = '0;
    logic        overflow;
    logic [15:0] drop_cnt;

    nms_corner_collector_if sif();

    nms_corner_collector #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .MAX_CORNERS (MAX_CORNERS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .win_vld     (win_vld),
        .w00         (w00),
        .w01         (w01),
        .w02         (w02),
        .w10         (w10),
        .w11         (w11),
        .w12         (w12),
        .w20         (w20),
        .w21         (w21),
        .w22         (w22),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .stream      (sif),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   word_idx = 0;
    exp_t exp_q[$];
    win_t frame_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    // 0: always ready, 1: random ready, 2: fully stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       sif.m_ready = 1'b1;
            1:       sif.m_ready = 1'($urandom_range(0, 1));
            default: sif.m_ready = 1'b0;
        endcase
    end

    function automatic logic [REC_W-1:0] rec(input int x, input int y, input bit ic, input int s);
        return {10'(x), 10'(y), ic, 13'(s)};
    endfunction

    // Index 4 is the centre; indices below it precede it in raster order.
    function automatic bit survives(input win_t win);
        int c, n;
        if (!win[4][IS_CORNER_BIT]) return 1'b0;
        c = int'(win[4][SCORE_MSB:0]);
        for (int k = 0; k < 9; k++) begin
            if (k == 4) continue;
            n = win[k][IS_CORNER_BIT] ? int'(win[k][SCORE_MSB:0]) : 0;
            if (k < 4 && c <= n) return 1'b0;
            if (k > 4 && c < n) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic win_t flatWin(input int cx, input int cy, input int cs, input int ns);
        win_t w;
        for (int k = 0; k < 9; k++) begin
            w[k] = (k == 4) ? rec(cx, cy, 1'b1, cs) : rec(cx + (k % 3) - 1, cy + (k / 3) - 1, 1'b1, ns);
        end
        return w;
    endfunction

    function automatic win_t genSurvivor(input int x, input int y);
        win_t w;
        int   c;
        c = int'($urandom_range(200, 8000));
        for (int k = 0; k < 9; k++) begin
            if (k == 4) w[k] = rec(x, y, 1'b1, c);
            else w[k] = rec(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                            1'($urandom_range(0, 1)), int'($urandom_range(0, c - 1)));
        end
        return w;
    endfunction

    function automatic win_t genRandom(input int x, input int y);
        win_t w;
        for (int k = 0; k < 9; k++) begin
            w[k] = rec((k == 4) ? x : int'($urandom_range(0, 1023)),
                       (k == 4) ? y : int'($urandom_range(0, 1023)),
                       ($urandom_range(0, 3) != 0),
                       (k == 4) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 15)));
        end
        return w;
    endfunction

    task automatic setWin(input win_t w);
        w00 = w[0]; w01 = w[1]; w02 = w[2];
        w10 = w[3]; w11 = w[4]; w12 = w[5];
        w20 = w[6]; w21 = w[7]; w22 = w[8];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Predicts the frame's output words, then drives frame_start, the windows and frame_end.
    task automatic applyStimulus(input bit ce_toggle, input bit finish_frame, input bit stalled);
        int   stored = 0;
        int   drops = 0;
        win_t w;
        if (finish_frame) begin
            foreach (frame_q[i]) begin
                w = frame_q[i];
                if (survives(w)) begin
                    if (stored < MAX_CORNERS && (!stalled || stored < FIFO_DEPTH - 1)) begin
                        exp_q.push_back('{data: {w[4][X_MSB:X_LSB], w[4][Y_MSB:Y_LSB], w[4][SCORE_MSB:0]},
                                          last: 1'b0, drops: 16'd0});
                        stored++;
                    end else begin
                        drops++;
                    end
                end
            end
            exp_q.push_back('{data: {20'd0, 13'(stored)}, last: 1'b1, drops: 16'(drops)});
        end
        ce = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        foreach (frame_q[i]) begin
            if (!ce_toggle && $urandom_range(0, 3) == 0) begin
                win_vld = 1'b0;
                setWin(genRandom(1000, 1000));
                @(posedge clk); #1;
            end
            ce = 1'b1;
            win_vld = 1'b1;
            setWin(frame_q[i]);
            frame_end = finish_frame && (i == frame_q.size() - 1);
            @(posedge clk); #1;
            frame_end = 1'b0;
            if (ce_toggle) begin
                ce = 1'b0;
                win_vld = 1'b1;
                setWin(genSurvivor(1023, 1023));
                @(posedge clk); #1;
            end
        end
        ce = 1'b1;
        win_vld = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            if (exp_q.size() == 0 && !sif.m_valid) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sif.m_valid && sif.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL word_%0d: got data=%h last=%b, required no word", word_idx,
                         sif.m_data, sif.m_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (sif.m_data !== mon_e.data || sif.m_last !== mon_e.last) begin
                    errors++;
                    $display("[TB] FAIL word_%0d: got data=%h last=%b, required data=%h last=%b",
                             word_idx, sif.m_data, sif.m_last, mon_e.data, mon_e.last);
                end
                if (mon_e.last) begin
                    checks += 2;
                    if (drop_cnt !== mon_e.drops) begin
                        errors++;
                        $display("[TB] FAIL eof_drop_cnt: got %0d, required %0d", drop_cnt, mon_e.drops);
                    end
                    if (overflow !== (mon_e.drops != 0)) begin
                        errors++;
                        $display("[TB] FAIL eof_overflow: got %b, required %b", overflow, mon_e.drops != 0);
                    end
                end
            end
            word_idx++;
        end
    end

    initial begin
        win_t w;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_m_valid", 32'(sif.m_valid), 32'd0);
        checkOutput("reset_m_last", 32'(sif.m_last), 32'd0);
        checkOutput("reset_m_data", 32'(sif.m_data), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        frame_q.delete();
        frame_q.push_back(flatWin(5, 7, 100, 50));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDrain("single_peak");

        frame_q.delete();
        w = flatWin(10, 3, 80, 20);
        w[5] = rec(11, 3, 1'b1, 80);
        frame_q.push_back(w);
        w = flatWin(11, 3, 80, 20);
        w[3] = rec(10, 3, 1'b1, 80);
        frame_q.push_back(w);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDrain("tie");

        ready_mode = 1;
        for (int f = 0; f < 5; f++) begin
            frame_q.delete();
            for (int i = 0; i < int'($urandom_range(5, 40)); i++) frame_q.push_back(genRandom(i % 16, i / 16));
            applyStimulus(1'b0, 1'b1, 1'b0);
            waitDrain("random_frame");
        end

        frame_q.delete();
        for (int i = 0; i < 30; i++) frame_q.push_back(genRandom(i, 2));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDrain("ce_ref");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitDrain("ce_toggle");

        ready_mode = 2;
        @(posedge clk); #1;
        frame_q.delete();
        for (int i = 0; i < 70; i++) frame_q.push_back(genSurvivor(i, 9));
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_drop_cnt", 32'(drop_cnt), 32'd7);
        checkOutput("stall_overflow", 32'(overflow), 32'd1);
        checkOutput("stall_m_valid", 32'(sif.m_valid), 32'd1);
        ready_mode = 1;
        waitDrain("backpressure");

        ready_mode = 2;
        @(posedge clk); #1;
        frame_q.delete();
        for (int i = 0; i < 10; i++) frame_q.push_back(genSurvivor(i, 11));
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("prereset_m_valid", 32'(sif.m_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_m_valid", 32'(sif.m_valid), 32'd0);
        checkOutput("midreset_m_data", 32'(sif.m_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        frame_q.delete();
        for (int i = 0; i < 3; i++) frame_q.push_back(genSurvivor(i, 12));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDrain("after_reset");

        frame_q.delete();
        for (int i = 0; i < MAX_CORNERS + 3; i++) frame_q.push_back(genSurvivor(i % 1000, i / 1000));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDrain("corner_cap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
